// File: rtl/ram_rd_ctrl.sv
// ram_rd_ctrl: reads the single-sided FFT modulus spectrum back out of the
// spectrum RAM once the write side has finished. It keeps a running top-two
// list of local maxima and holds the two peaks plus a sticky done flag.
// Optional feature macro: PEAK_THRESH_EN. When it is defined, a peak must
// also reach MIN_AMP.
module ram_rd_ctrl #(
   parameter int          addr_300k = 2048,
   parameter int          RD_LAT    = 1,
   parameter int          SKIP_BINS = 2,
   parameter logic [15:0] MIN_AMP   = 16'd64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_done,
   input  logic [15:0] rd_data,
   output logic        rd_en,
   output logic [11:0] rd_addr,
   output logic [11:0] peak1_addr,
   output logic [15:0] peak1_amp,
   output logic [11:0] peak2_addr,
   output logic [15:0] peak2_amp,
   output logic [1:0]  peak_num,
   output logic        rd_done
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [11:0] LAST_BIN = 12'(addr_300k - 1);
   localparam logic [11:0] LAST_M1  = 12'(addr_300k - 2);
   localparam logic [11:0] SKIP     = 12'(SKIP_BINS);

   state_t      state_q, state_d;
   logic        wr_q, wr_armed, wr_rise;
   logic [11:0] addr_q;
   logic        pipe_v   [RD_LAT];
   logic [11:0] pipe_bin [RD_LAT];
   logic        smp_v;
   logic [11:0] smp_bin;
   logic        cur_v;
   logic [11:0] cur_bin;
   logic [15:0] prev_amp, cur_amp;
   logic        thr_ok, is_peak;

   // wr_done edge detect; armed only after wr_done has been seen low since reset
   // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q     <= 1'b0;
         wr_armed <= 1'b0;
      end else begin
         wr_q     <= wr_done;
         wr_armed <= wr_armed | ~wr_done;
      end
   end

   assign wr_rise = wr_q & wr_armed;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and control outputs
   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      rd_done = 1'b0;
      case (state_q)
         IDLE:  if (wr_rise) state_d = READ;
         READ: begin
            rd_en = 1'b1;
            if (addr_q == LAST_BIN) state_d = DRAIN;
         end
         DRAIN: if (cur_v && cur_bin == LAST_BIN) state_d = DONE;
         DONE:  rd_done = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   // Read address sweeps 0..addr_300k-1 once, then holds at the last bin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    addr_q <= '0;
      else if (state_q == READ && addr_q != LAST_BIN) addr_q <= addr_q + 12'd1;
   end

   assign rd_addr = addr_q;

   // Valid flag and bin tag delayed to line up with the RAM read latency
   // NOTE: this small pipeline array is reset so stale valids cannot fire after a mid-scan reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i]   <= 1'b0;
            pipe_bin[i] <= '0;
         end
      end else begin
         pipe_v[0]   <= rd_en;
         pipe_bin[0] <= addr_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_bin[i] <= pipe_bin[i-1];
         end
      end
   end

   assign smp_v   = pipe_v[RD_LAT-1];
   assign smp_bin = pipe_bin[RD_LAT-1];

   // Window: prev/cur are registered, the live rd_data sample acts as next
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_amp <= '0;
         cur_amp  <= '0;
         cur_bin  <= '0;
         cur_v    <= 1'b0;
      end else if (smp_v) begin
         prev_amp <= cur_amp;
         cur_amp  <= rd_data;
         cur_bin  <= smp_bin;
         cur_v    <= 1'b1;
      end
   end

`ifdef PEAK_THRESH_EN
   assign thr_ok = (cur_amp >= MIN_AMP);
`else
   logic unused_min_amp;
   assign unused_min_amp = ^MIN_AMP;
   assign thr_ok         = 1'b1;
`endif

   // cur is a peak once its right neighbour is on rd_data
   assign is_peak = smp_v && cur_v && thr_ok
                    && (cur_bin >= SKIP) && (cur_bin >= 12'd1) && (cur_bin <= LAST_M1)
                    && (cur_amp > prev_amp) && (cur_amp >= rd_data);

   // Running top-two list; strict compares keep the lower bin on ties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak1_addr <= '0;
         peak1_amp  <= '0;
         peak2_addr <= '0;
         peak2_amp  <= '0;
         peak_num   <= '0;
      end else if (is_peak) begin
         if (cur_amp > peak1_amp) begin
            peak2_addr <= peak1_addr;
            peak2_amp  <= peak1_amp;
            peak1_addr <= cur_bin;
            peak1_amp  <= cur_amp;
         end else if (cur_amp > peak2_amp) begin
            peak2_addr <= cur_bin;
            peak2_amp  <= cur_amp;
         end
         if (peak_num != 2'd2) peak_num <= peak_num + 2'd1;
      end
   end

endmodule

// File: tb/tb_ram_rd_ctrl.sv
// Testbench for ram_rd_ctrl: random and directed spectra against a reference
// peak model, with a scoreboard monitor on the read port and the done flag.
module tb_ram_rd_ctrl;

   localparam int          N       = 16;
   localparam int          LAT     = 1;
   localparam int          SKIP    = 2;
   localparam logic [15:0] MIN_AMP = 16'd64;

   typedef logic [15:0] spec_t [N];
   typedef struct {
      logic [11:0] a1;
      logic [15:0] m1;
      logic [11:0] a2;
      logic [15:0] m2;
      logic [1:0]  num;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_done = 1'b0;
   logic [15:0] rd_data = '0;
   logic        rd_en;
   logic [11:0] rd_addr;
   logic [11:0] peak1_addr, peak2_addr;
   logic [15:0] peak1_amp, peak2_amp;
   logic [1:0]  peak_num;
   logic        rd_done;

   spec_t mem;
   res_t  cur_exp;
   int    n_chk = 0;
   int    n_err = 0;
   int    exp_addr[$];
   res_t  exp_res[$];

   always #5 clk = ~clk;

   ram_rd_ctrl #(
      .addr_300k(N), .RD_LAT(LAT), .SKIP_BINS(SKIP), .MIN_AMP(MIN_AMP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_done(wr_done), .rd_data(rd_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .peak1_addr(peak1_addr), .peak1_amp(peak1_amp),
      .peak2_addr(peak2_addr), .peak2_amp(peak2_amp),
      .peak_num(peak_num), .rd_done(rd_done)
   );

   // Spectrum RAM with one cycle of read latency
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[3:0]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: collect every qualifying local maximum, then take the two
   // largest, lowest bin first among equals.
   function automatic res_t model(input spec_t d);
      res_t r;
      int   pk[$];
      int   best;
      r = '{a1: '0, m1: '0, a2: '0, m2: '0, num: '0};
      for (int k = 1; k <= N - 2; k++) begin
         if (k >= SKIP && d[k] > d[k-1] && d[k] >= d[k+1]
`ifdef PEAK_THRESH_EN
             && d[k] >= MIN_AMP
`endif
            ) pk.push_back(k);
      end
      r.num = (pk.size() >= 2) ? 2'd2 : 2'(pk.size());
      for (int slot = 0; slot < 2; slot++) begin
         if (pk.size() > 0) begin
            best = 0;
            for (int j = 1; j < pk.size(); j++)
               if (d[pk[j]] > d[pk[best]]) best = j;
            if (slot == 0) begin
               r.a1 = 12'(pk[best]);
               r.m1 = d[pk[best]];
            end else begin
               r.a2 = 12'(pk[best]);
               r.m2 = d[pk[best]];
            end
            pk.delete(best);
         end
      end
      return r;
   endfunction

   // Monitor: pops expected addresses on each rd_en cycle and the expected
   // result when rd_done rises.
   int   m_cyc = 0;
   int   m_last_en = 0;
   int   m_en_cnt = 0;
   logic m_done_prev = 1'b0;
   res_t m_r;

   initial begin
      forever begin
         @(negedge clk);
         m_cyc++;
         if (!rst_n) begin
            m_en_cnt    = 0;
            m_done_prev = 1'b0;
         end else begin
            if (rd_en) begin
               m_en_cnt++;
               m_last_en = m_cyc;
               if (exp_addr.size() == 0) check("rd_en_unexpected", 32'(rd_en), 32'd0);
               else                      check("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
            end
            if (rd_done && !m_done_prev) begin
               if (exp_res.size() == 0) begin
                  check("rd_done_unexpected", 32'(rd_done), 32'd0);
               end else begin
                  m_r = exp_res.pop_front();
                  check("done_latency", 32'(m_cyc - m_last_en), 32'(LAT + 2));
                  check("rd_en_cycles", 32'(m_en_cnt), 32'(N));
                  check("peak1", 32'({peak1_addr, peak1_amp}), 32'({m_r.a1, m_r.m1}));
                  check("peak2", 32'({peak2_addr, peak2_amp}), 32'({m_r.a2, m_r.m2}));
                  check("peak_num", 32'(peak_num), 32'(m_r.num));
               end
               m_en_cnt = 0;
            end
            m_done_prev = rd_done;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic wr_level);
      rst_n   = 1'b0;
      wr_done = wr_level;
      exp_addr.delete();
      exp_res.delete();
      tick();
      tick();
      check("reset_ctrl", 32'({rd_en, rd_done, rd_addr, peak_num}), 32'd0);
      check("reset_amps", 32'({peak1_amp, peak2_amp}), 32'd0);
      check("reset_bins", 32'({peak1_addr, peak2_addr}), 32'd0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic quiet(input int cycles, input string name);
      int hits;
      hits = 0;
      repeat (cycles) begin
         tick();
         if (rd_en) hits++;
      end
      check(name, 32'(hits), 32'd0);
   endtask

   task automatic start_scan();
      cur_exp = model(mem);
      exp_res.push_back(cur_exp);
      for (int k = 0; k < N; k++) exp_addr.push_back(k);
      wr_done = 1'b1;
      tick();
      check("start_wait", 32'(rd_en), 32'd0);
      tick();
      check("start_first", 32'({rd_en, rd_addr}), 32'({1'b1, 12'd0}));
   endtask

   task automatic finish_scan();
      int n;
      n = 0;
      while (!rd_done && n < 100) begin
         tick();
         n++;
      end
      if (!rd_done) check("done_timeout", 32'(rd_done), 32'd1);
      wr_done = 1'b0;
      tick(); tick();
      wr_done = 1'b1;
      tick(); tick();
      wr_done = 1'b0;
      tick();
      wr_done = 1'b1;
      quiet(8, "done_no_restart");
      check("done_held", 32'(rd_done), 32'd1);
      check("done_p1", 32'({peak1_addr, peak1_amp}), 32'({cur_exp.a1, cur_exp.m1}));
      check("done_p2", 32'({peak2_addr, peak2_amp}), 32'({cur_exp.a2, cur_exp.m2}));
      check("done_num", 32'(peak_num), 32'(cur_exp.num));
   endtask

   task automatic run_scan();
      do_reset(1'b0);
      start_scan();
      finish_scan();
   endtask

   initial begin
      int n;

      // Two peaks, larger one later in the sweep
      mem = '{default: 16'd0};
      mem[3] = 16'd5;
      mem[8] = 16'd9;
      run_scan();

      // Skipped DC bin and the top edge bin never qualify
      mem = '{default: 16'd0};
      mem[1]  = 16'd50;
      mem[15] = 16'd50;
      run_scan();

      // Plateau and tie handling
      mem = '{default: 16'd0};
      mem[5]  = 16'd7;
      mem[6]  = 16'd7;
      mem[10] = 16'd7;
      run_scan();

      // Threshold case (with the feature off, both maxima count)
      mem = '{default: 16'd0};
      mem[4] = 16'd40;
      mem[9] = 16'd100;
      run_scan();

      // Random spectra with small values to provoke ties and plateaus
      for (int s = 0; s < 10; s++) begin
         for (int k = 0; k < N; k++) mem[k] = 16'($urandom_range(15, 0));
         if (s % 3 == 0) mem[$urandom_range(N - 1, 0)] = 16'($urandom_range(65535, 1000));
         run_scan();
      end

      // Reset in the middle of a scan, then a fresh full scan
      for (int k = 0; k < N; k++) mem[k] = 16'($urandom_range(30, 0));
      do_reset(1'b0);
      start_scan();
      n = 0;
      while (rd_addr != 12'd7 && n < 50) begin
         tick();
         n++;
      end
      check("midscan_reach", 32'(rd_addr), 32'd7);
      do_reset(1'b0);
      quiet(20, "post_reset_idle");
      check("post_reset_outs", 32'({rd_done, peak_num, peak1_amp, rd_addr}), 32'd0);
      start_scan();
      finish_scan();

      // wr_done already high when reset releases: no edge, no scan
      do_reset(1'b1);
      quiet(20, "held_high_no_scan");
      check("held_high_done", 32'(rd_done), 32'd0);

      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
